// File: rtl/contador16_ctrl.sv
// Command sequencer for a 16-bit cascaded counter: one load/count command at a time,
// early stop on target match, completion status and wrap accounting.
module contador16_ctrl #(
  parameter int unsigned W      = 16,
  parameter int unsigned STEP_W = 16,
  parameter int unsigned SETTLE = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_op,
  input  logic [W-1:0]  cmd_data,
  input  logic          cmd_tgt_en,
  input  logic [W-1:0]  cmd_target,
  input  logic          abort,
  output logic          cnt_enb,
  output logic [1:0]    cnt_modo,
  output logic [W-1:0]  cnt_D,
  input  logic [W-1:0]  cnt_Q,
  input  logic [3:0]    cnt_RCO,
  output logic          busy,
  output logic          done,
  output logic [1:0]    status,
  output logic [7:0]    wrap_cnt
);

  localparam int unsigned SetW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [2:0] {StIdle, StLoad, StSettle, StRun, StDone} state_e;

  state_e            state_q, state_d;
  logic [1:0]        op_q, op_d;
  logic [W-1:0]      data_q, data_d;
  logic [W-1:0]      target_q, target_d;
  logic              tgt_en_q, tgt_en_d;
  logic [STEP_W-1:0] remaining_q, remaining_d;
  logic [SetW-1:0]   settle_q, settle_d;
  logic [1:0]        status_q, status_d;
  logic [7:0]        wrap_q, wrap_d;

  logic accept;
  logic tgt_hit;
  logic unused_rco;

  // Only the full-width carry/borrow matters; the nibble carries are internal to the counter.
  assign unused_rco = ^cnt_RCO[2:0];

  assign accept   = cmd_valid & cmd_ready;
  assign tgt_hit  = tgt_en_q & (cnt_Q == target_q);
  assign busy     = (state_q != StIdle);
  assign done     = (state_q == StDone);
  assign status   = status_q;
  assign wrap_cnt = wrap_q;

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    data_d      = data_q;
    target_d    = target_q;
    tgt_en_d    = tgt_en_q;
    remaining_d = remaining_q;
    settle_d    = settle_q;
    status_d    = status_q;
    wrap_d      = wrap_q;
    cmd_ready   = 1'b0;
    cnt_enb     = 1'b0;
    cnt_modo    = 2'b00;
    cnt_D       = '0;

    unique case (state_q)
      StIdle: begin
        cmd_ready = ~reset;
        if (accept) begin
          op_d     = cmd_op;
          data_d   = cmd_data;
          tgt_en_d = cmd_tgt_en;
          target_d = cmd_target;
          wrap_d   = 8'd0;
          status_d = 2'b00;
          if (cmd_op == 2'b11) begin
            state_d = StLoad;
          end else if (STEP_W'(cmd_data) == '0) begin
            state_d  = StDone;
            status_d = 2'b11;
          end else begin
            state_d     = StRun;
            remaining_d = STEP_W'(cmd_data);
          end
        end
      end
      StLoad: begin
        // The load is driven this cycle even if aborted; it cannot be taken back.
        cnt_enb  = 1'b1;
        cnt_modo = 2'b11;
        cnt_D    = data_q;
        settle_d = SetW'(SETTLE - 1);
        if (abort) begin
          state_d  = StDone;
          status_d = 2'b10;
        end else begin
          state_d = StSettle;
        end
      end
      StSettle: begin
        if (abort) begin
          state_d  = StDone;
          status_d = 2'b10;
        end else if (settle_q == '0) begin
          state_d  = StDone;
          status_d = 2'b00;
        end else begin
          settle_d = settle_q - 1'b1;
        end
      end
      StRun: begin
        cnt_modo = op_q;
        if (abort) begin
          state_d  = StDone;
          status_d = 2'b10;
        end else if (tgt_hit) begin
          // Match is checked before stepping so the counter never overshoots.
          state_d  = StDone;
          status_d = 2'b01;
        end else begin
          cnt_enb     = 1'b1;
          remaining_d = remaining_q - 1'b1;
          if (cnt_RCO[3] && (wrap_q != 8'hFF)) begin
            wrap_d = wrap_q + 8'd1;
          end
          if (remaining_q == STEP_W'(1)) begin
            state_d  = StDone;
            status_d = 2'b00;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      op_q        <= 2'b00;
      data_q      <= '0;
      target_q    <= '0;
      tgt_en_q    <= 1'b0;
      remaining_q <= '0;
      settle_q    <= '0;
      status_q    <= 2'b00;
      wrap_q      <= 8'd0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      data_q      <= data_d;
      target_q    <= target_d;
      tgt_en_q    <= tgt_en_d;
      remaining_q <= remaining_d;
      settle_q    <= settle_d;
      status_q    <= status_d;
      wrap_q      <= wrap_d;
    end
  end

endmodule

// File: tb/tb_contador16_ctrl.sv
// Bench for contador16_ctrl: behavioural counter plus an arithmetic reference model of
// each command's outcome (steps, stop reason, wraps, final value, completion cycle).
module tb_contador16_ctrl;

  localparam int SETTLE = 2;

  logic        clk;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [15:0] cmd_data;
  logic        cmd_tgt_en;
  logic [15:0] cmd_target;
  logic        abort;
  logic        cnt_enb;
  logic [1:0]  cnt_modo;
  logic [15:0] cnt_D;
  logic [15:0] cnt_Q;
  logic [3:0]  cnt_RCO;
  logic        busy;
  logic        done;
  logic [1:0]  status;
  logic [7:0]  wrap_cnt;

  int checks = 0;
  int errors = 0;

  contador16_ctrl #(
    .W      (16),
    .STEP_W (16),
    .SETTLE (SETTLE)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_data   (cmd_data),
    .cmd_tgt_en (cmd_tgt_en),
    .cmd_target (cmd_target),
    .abort      (abort),
    .cnt_enb    (cnt_enb),
    .cnt_modo   (cnt_modo),
    .cnt_D      (cnt_D),
    .cnt_Q      (cnt_Q),
    .cnt_RCO    (cnt_RCO),
    .busy       (busy),
    .done       (done),
    .status     (status),
    .wrap_cnt   (wrap_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural 16-bit counter the controller drives.
  logic [15:0] q;
  logic        rco3;
  assign cnt_Q   = q;
  assign cnt_RCO = {cnt_enb & rco3, 3'b000};

  always_comb begin
    rco3 = 1'b0;
    case (cnt_modo)
      2'b00:   rco3 = (q == 16'hFFFF);
      2'b01:   rco3 = (q == 16'h0000);
      2'b10:   rco3 = (q < 16'd3);
      default: rco3 = 1'b0;
    endcase
  end

  always @(posedge clk) begin
    if (cnt_enb) begin
      case (cnt_modo)
        2'b00:   q <= q + 16'd1;
        2'b01:   q <= q - 16'd1;
        2'b10:   q <= q - 16'd3;
        default: q <= cnt_D;
      endcase
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Outcome of one command; cycle 0 is the first cycle after the accept edge.
  function automatic void ref_model(input logic [1:0] op, input logic [15:0] n, input logic ten,
                                    input logic [15:0] tgt, input logic [15:0] q0,
                                    input int abort_at, output logic [1:0] st, output int enbs,
                                    output int wraps, output logic [15:0] qf,
                                    output int done_at);
    int delta;
    int nxt;
    st = 2'b00; enbs = 0; wraps = 0; qf = q0; done_at = 0;
    if (op == 2'b11) begin
      qf = n; enbs = 1;
      if (abort_at >= 0 && abort_at <= SETTLE) begin
        st = 2'b10; done_at = abort_at + 1;
      end else begin
        st = 2'b00; done_at = SETTLE + 1;
      end
    end else if (n == 16'd0) begin
      st = 2'b11; done_at = 0;
    end else begin
      delta = (op == 2'b00) ? 1 : (op == 2'b01) ? -1 : -3;
      while (1) begin
        if (abort_at == enbs) begin st = 2'b10; break; end
        if (ten && qf == tgt) begin st = 2'b01; break; end
        nxt = int'(qf) + delta;
        if (nxt < 0 || nxt > 65535) wraps++;
        qf = 16'(nxt);
        enbs++;
        if (enbs == int'(n)) begin st = 2'b00; break; end
      end
      done_at = (st == 2'b00) ? enbs : enbs + 1;
      if (wraps > 255) wraps = 255;
    end
  endfunction

  task automatic run_cmd(input string tag, input logic [1:0] op, input logic [15:0] data,
                         input logic ten, input logic [15:0] tgt, input int abort_at,
                         input bit hold_valid);
    logic [1:0]  e_st;
    logic [15:0] e_q;
    int          e_enbs, e_wraps, e_done;
    int          enbs, d_bad, busy_bad, done_at;
    bit          load_ok;
    ref_model(op, data, ten, tgt, q, abort_at, e_st, e_enbs, e_wraps, e_q, e_done);
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_op = op; cmd_data = data; cmd_tgt_en = ten; cmd_target = tgt;
    #1;
    check({tag, ".ready"}, 32'(cmd_ready), 32'd1);
    @(posedge clk);
    enbs = 0; d_bad = 0; busy_bad = 0; done_at = -1; load_ok = (op != 2'b11);
    for (int i = 0; i < 300; i++) begin
      #1;
      abort = (i == abort_at);
      if (!hold_valid) cmd_valid = 1'b0;
      #1;
      if (cnt_enb) enbs++;
      if (cnt_modo != 2'b11 && cnt_D != 16'd0) d_bad++;
      if (op == 2'b11 && i == 0) load_ok = cnt_enb && cnt_modo == 2'b11 && cnt_D == data;
      if (cmd_ready || !busy) busy_bad++;
      if (done) begin done_at = i; break; end
      @(posedge clk);
    end
    abort = 1'b0; cmd_valid = 1'b0;
    check({tag, ".done_cycle"}, 32'(done_at), 32'(e_done));
    check({tag, ".status"}, 32'(status), 32'(e_st));
    check({tag, ".wrap_cnt"}, 32'(wrap_cnt), 32'(e_wraps));
    check({tag, ".q"}, 32'(q), 32'(e_q));
    check({tag, ".enb_cycles"}, 32'(enbs), 32'(e_enbs));
    check({tag, ".d_outside_load"}, 32'(d_bad), 32'd0);
    check({tag, ".busy_not_ready"}, 32'(busy_bad), 32'd0);
    check({tag, ".load_cycle"}, 32'(load_ok), 32'd1);
    @(posedge clk); #2;
    check({tag, ".idle"}, {29'd0, done, busy, cmd_ready}, 32'b001);
    check({tag, ".status_hold"}, 32'(status), 32'(e_st));
    check({tag, ".wrap_hold"}, 32'(wrap_cnt), 32'(e_wraps));
  endtask

  logic [1:0]  r_op;
  logic [15:0] r_data, r_tgt, q_start;
  logic        r_ten;
  int          r_abort, r_delta, sel, done_seen;
  bit          r_hold;

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_data = 16'd0;
    cmd_tgt_en = 1'b0; cmd_target = 16'd0; abort = 1'b0;

    // Reset state, with a command offered that must not be accepted.
    repeat (3) @(posedge clk);
    #1 cmd_valid = 1'b1;
    #1;
    check("reset.ready", 32'(cmd_ready), 32'd0);
    check("reset.outs", {12'd0, cnt_enb, cnt_modo, cnt_D, busy}, 32'd0);
    check("reset.stat", {21'd0, done, status, wrap_cnt}, 32'd0);
    @(posedge clk); #1;
    cmd_valid = 1'b0; reset = 1'b0;
    @(posedge clk); #2;
    check("release.ready", 32'(cmd_ready), 32'd1);
    check("release.busy", 32'(busy), 32'd0);

    run_cmd("t1_load_fffe", 2'b11, 16'hFFFE, 1'b0, 16'd0, -1, 1'b0);
    check("t1.q_const", 32'(q), 32'h0000FFFE);
    run_cmd("t2_up4", 2'b00, 16'd4, 1'b0, 16'd0, -1, 1'b0);
    check("t2.q_const", 32'(q), 32'h00000002);
    check("t2.wrap_const", 32'(wrap_cnt), 32'd1);
    run_cmd("t3_load_0010", 2'b11, 16'h0010, 1'b0, 16'd0, -1, 1'b0);
    run_cmd("t3_down3_tgt", 2'b10, 16'd10, 1'b1, 16'h0004, -1, 1'b0);
    check("t3.q_const", 32'(q), 32'h00000004);
    check("t3.status_const", 32'(status), 32'd1);
    run_cmd("t4_up0", 2'b00, 16'd0, 1'b0, 16'd0, -1, 1'b0);
    check("t4.status_const", 32'(status), 32'd3);
    run_cmd("t4_abort_run3", 2'b00, 16'd10, 1'b0, 16'd0, 3, 1'b0);
    check("t4b.status_const", 32'(status), 32'd2);
    run_cmd("abort_settle", 2'b11, 16'h1234, 1'b0, 16'd0, 1, 1'b0);
    run_cmd("abort_load", 2'b11, 16'h5555, 1'b0, 16'd0, 0, 1'b0);
    run_cmd("tgt_first", 2'b00, 16'd5, 1'b1, q, -1, 1'b0);
    run_cmd("hold_valid", 2'b01, 16'd6, 1'b0, 16'd0, -1, 1'b1);
    run_cmd("load_0001", 2'b11, 16'h0001, 1'b0, 16'd0, -1, 1'b0);
    run_cmd("down3_wrap", 2'b10, 16'd5, 1'b0, 16'd0, -1, 1'b0);
    run_cmd("abort_at_done", 2'b01, 16'd2, 1'b0, 16'd0, 2, 1'b0);

    // Abort while idle has no effect.
    @(posedge clk); #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    #1 check("idle_abort.busy", {30'd0, busy, cmd_ready}, 32'b01);

    // Reset in the middle of a count.
    q_start = q;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_op = 2'b00; cmd_data = 16'd20; cmd_tgt_en = 1'b0;
    @(posedge clk); #1 cmd_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #2;
    check("rst_mid.outs", {28'd0, cnt_enb, busy, done, cmd_ready}, 32'd0);
    check("rst_mid.q", 32'(q), 32'(16'(q_start + 16'd4)));
    reset = 1'b0;
    done_seen = 0;
    repeat (4) begin
      @(posedge clk); #2;
      if (done || busy || cnt_enb) done_seen++;
    end
    check("rst_mid.no_done", 32'(done_seen), 32'd0);

    for (int k = 0; k < 40; k++) begin
      r_op = 2'($urandom_range(0, 3));
      if (r_op == 2'b11) begin
        sel = int'($urandom_range(0, 3));
        if (sel == 0) r_data = 16'hFFFF - 16'($urandom_range(0, 5));
        else if (sel == 1) r_data = 16'($urandom_range(0, 5));
        else r_data = 16'($urandom);
      end else begin
        r_data = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom_range(1, 24));
      end
      r_delta = (r_op == 2'b00) ? 1 : (r_op == 2'b01) ? -1 : -3;
      r_ten   = 1'($urandom_range(0, 1));
      r_tgt   = 16'(int'(q) + r_delta * int'($urandom_range(0, 30)));
      r_abort = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 12)) : -1;
      r_hold  = ($urandom_range(0, 3) == 0);
      run_cmd($sformatf("rnd%0d", k), r_op, r_data, r_ten, r_tgt, r_abort, r_hold);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
